// File: rtl/gpr_muldiv_unit.sv
// Iterative unsigned MUL/MULHU/DIVU/REMU unit feeding the GPR write port.
// Ports: clk/rst_n, issue_* handshake + operands, flush, busy, reg_write_*.
module gpr_muldiv_unit #(
  parameter int XLEN = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            issue_valid,
  output logic            issue_ready,
  input  logic [1:0]      issue_op,
  input  logic [2:0]      issue_rd,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            busy,
  output logic            reg_write_en,
  output logic [2:0]      reg_write_dest,
  output logic [XLEN-1:0] reg_write_data
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_WB
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic [1:0]      r_op;
  logic [2:0]      r_rd;
  logic [XLEN-1:0] r_hi;
  logic [XLEN-1:0] r_lo;
  logic [XLEN-1:0] r_opnd;
  logic [XLEN-1:0] r_wdata;
  logic [2:0]      r_wdest;

  logic            w_accept;
  logic            w_last;
  logic [XLEN:0]   w_sum;
  logic [XLEN:0]   w_sh;
  logic [XLEN:0]   w_diff;
  logic [XLEN-1:0] w_hi_nxt;
  logic [XLEN-1:0] w_lo_nxt;
  logic [XLEN-1:0] w_res;

  assign w_accept = issue_valid && (r_state == S_IDLE) && !flush;
  assign w_last   = (r_cnt == CW'(XLEN - 1));

  // MUL: r_hi:r_lo is the product, r_lo starts as the multiplier.
  // DIV: r_hi is the partial remainder, r_lo shifts dividend out
  // and quotient bits in. A zero divisor naturally yields q=~0, r=a.
  assign w_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : '0);
  assign w_sh   = {r_hi, r_lo[XLEN-1]};
  assign w_diff = w_sh - {1'b0, r_opnd};

  always_comb begin
    w_hi_nxt = r_hi;
    w_lo_nxt = r_lo;
    if (!r_op[1]) begin
      w_hi_nxt = w_sum[XLEN:1];
      w_lo_nxt = {w_sum[0], r_lo[XLEN-1:1]};
    end else if (!w_diff[XLEN]) begin
      w_hi_nxt = w_diff[XLEN-1:0];
      w_lo_nxt = {r_lo[XLEN-2:0], 1'b1};
    end else begin
      w_hi_nxt = w_sh[XLEN-1:0];
      w_lo_nxt = {r_lo[XLEN-2:0], 1'b0};
    end
  end

  // MUL/DIVU take the low word, MULHU/REMU the high word.
  always_comb begin
    w_res = w_lo_nxt;
    unique case (r_op)
      2'b00, 2'b10: w_res = w_lo_nxt;
      default:      w_res = w_hi_nxt;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_nxt = S_CALC;
      end
      S_CALC: begin
        if (flush) begin
          w_state_nxt = S_IDLE;
        end else if (w_last) begin
          w_state_nxt = S_WB;
        end
      end
      S_WB:    w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_op    <= '0;
      r_rd    <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_opnd  <= '0;
      r_wdata <= '0;
      r_wdest <= '0;
    end else if (w_accept) begin
      r_op   <= issue_op;
      r_rd   <= issue_rd;
      r_cnt  <= '0;
      r_hi   <= '0;
      r_lo   <= issue_op[1] ? op_a : op_b;
      r_opnd <= issue_op[1] ? op_b : op_a;
    end else if (r_state == S_CALC && !flush) begin
      r_hi  <= w_hi_nxt;
      r_lo  <= w_lo_nxt;
      r_cnt <= r_cnt + CW'(1);
      if (w_last) begin
        r_wdata <= w_res;
        r_wdest <= r_rd;
      end
    end
  end

  assign issue_ready    = (r_state == S_IDLE);
  assign busy           = (r_state != S_IDLE);
  assign reg_write_en   = (r_state == S_WB);
  assign reg_write_dest = r_wdest;
  assign reg_write_data = r_wdata;

endmodule

// File: tb/tb_gpr_muldiv_unit.sv
// Directed bench for gpr_muldiv_unit (XLEN=16).
// Checks results, write timing, flush and async reset behaviour.
module tb_gpr_muldiv_unit;

  logic        clk;
  logic        rst_n;
  logic        issue_valid;
  logic        issue_ready;
  logic [1:0]  issue_op;
  logic [2:0]  issue_rd;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic        flush;
  logic        busy;
  logic        reg_write_en;
  logic [2:0]  reg_write_dest;
  logic [15:0] reg_write_data;

  int n_cmp;
  int n_err;

  gpr_muldiv_unit #(.XLEN(16)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .issue_valid    (issue_valid),
    .issue_ready    (issue_ready),
    .issue_op       (issue_op),
    .issue_rd       (issue_rd),
    .op_a           (op_a),
    .op_b           (op_b),
    .flush          (flush),
    .busy           (busy),
    .reg_write_en   (reg_write_en),
    .reg_write_dest (reg_write_dest),
    .reg_write_data (reg_write_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Entered and left at #1 after a clock edge with issue_ready high.
  task automatic run_op(input string tag, input logic [1:0] op,
                        input logic [2:0] rd, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] exp);
    int pulses;
    int at;
    int lowc;
    logic [15:0] d;
    logic [2:0] dst;
    pulses = 0;
    at = -1;
    lowc = 0;
    d = '0;
    dst = '0;
    chk({tag, " ready_pre"}, 32'(issue_ready), 32'd1);
    issue_op = op;
    issue_rd = rd;
    op_a = a;
    op_b = b;
    issue_valid = 1'b1;
    @(posedge clk);
    #1;
    issue_valid = 1'b0;
    op_a = ~a;
    op_b = b ^ 16'h5a5a;
    for (int k = 0; k <= 17; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      if (!issue_ready) lowc++;
      if (reg_write_en) begin
        pulses++;
        at = k;
        d = reg_write_data;
        dst = reg_write_dest;
      end
    end
    chk({tag, " pulses"}, 32'(pulses), 32'd1);
    chk({tag, " wb_cycle"}, 32'(at), 32'd16);
    chk({tag, " dest"}, 32'(dst), 32'(rd));
    chk({tag, " data"}, 32'(d), 32'(exp));
    chk({tag, " busy_cycles"}, 32'(lowc), 32'd17);
    chk({tag, " ready_post"}, 32'(issue_ready), 32'd1);
  endtask

  initial begin
    int acc;
    int pulses;
    logic [15:0] d1;
    logic [2:0] t1;
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    issue_valid = 1'b0;
    issue_op = '0;
    issue_rd = '0;
    op_a = '0;
    op_b = '0;
    flush = 1'b0;
    #1;
    chk("rst ready", 32'(issue_ready), 32'd1);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst we", 32'(reg_write_en), 32'd0);
    chk("rst dest", 32'(reg_write_dest), 32'd0);
    chk("rst data", 32'(reg_write_data), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_op("mul1", 2'b00, 3'd3, 16'h1234, 16'h0010, 16'h2340);
    run_op("mulhu_ff", 2'b01, 3'd5, 16'hFFFF, 16'hFFFF, 16'hFFFE);
    run_op("mul_ff", 2'b00, 3'd5, 16'hFFFF, 16'hFFFF, 16'h0001);
    run_op("mul_zero", 2'b00, 3'd0, 16'h0000, 16'hABCD, 16'h0000);
    run_op("divu", 2'b10, 3'd1, 16'd100, 16'd7, 16'h000E);
    run_op("remu", 2'b11, 3'd1, 16'd100, 16'd7, 16'h0002);
    run_op("divu_small", 2'b10, 3'd2, 16'h0005, 16'h0009, 16'h0000);
    run_op("remu_small", 2'b11, 3'd2, 16'h0005, 16'h0009, 16'h0005);
    run_op("divu_z", 2'b10, 3'd4, 16'h1234, 16'h0000, 16'hFFFF);
    run_op("remu_z", 2'b11, 3'd4, 16'h1234, 16'h0000, 16'h1234);

    // back-to-back with issue_valid held high
    issue_op = 2'b00;
    issue_rd = 3'd2;
    op_a = 16'd3;
    op_b = 16'd5;
    issue_valid = 1'b1;
    @(posedge clk);
    #1;
    issue_op = 2'b10;
    issue_rd = 3'd4;
    op_a = 16'd50;
    op_b = 16'd5;
    acc = -1;
    d1 = '0;
    t1 = '0;
    for (int k = 1; k <= 40 && acc < 0; k++) begin
      @(posedge clk);
      #1;
      if (reg_write_en) begin
        d1 = reg_write_data;
        t1 = reg_write_dest;
      end
      if (issue_ready) acc = k + 1;
    end
    @(posedge clk);
    #1;
    issue_valid = 1'b0;
    op_a = 16'hFFFF;
    op_b = 16'h0001;
    chk("b2b interval", 32'(acc), 32'd18);
    chk("b2b first data", 32'(d1), 32'd15);
    chk("b2b first dest", 32'(t1), 32'd2);
    chk("b2b second busy", 32'(busy), 32'd1);
    repeat (16) @(posedge clk);
    #1;
    chk("b2b second we", 32'(reg_write_en), 32'd1);
    chk("b2b second data", 32'(reg_write_data), 32'd10);
    chk("b2b second dest", 32'(reg_write_dest), 32'd4);
    @(posedge clk);
    #1;

    // flush with issue_valid in IDLE blocks acceptance
    issue_op = 2'b00;
    op_a = 16'd3;
    op_b = 16'd3;
    issue_valid = 1'b1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    issue_valid = 1'b0;
    flush = 1'b0;
    chk("idle flush ready", 32'(issue_ready), 32'd1);
    chk("idle flush busy", 32'(busy), 32'd0);

    // flush in the 5th CALC cycle
    issue_valid = 1'b1;
    @(posedge clk);
    #1;
    issue_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("calc flush busy_pre", 32'(busy), 32'd1);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("calc flush ready", 32'(issue_ready), 32'd1);
    chk("calc flush busy", 32'(busy), 32'd0);
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      if (reg_write_en) pulses++;
    end
    chk("calc flush no_write", 32'(pulses), 32'd0);

    // flush during WB is ignored
    issue_op = 2'b00;
    issue_rd = 3'd6;
    op_a = 16'd7;
    op_b = 16'd6;
    issue_valid = 1'b1;
    @(posedge clk);
    #1;
    issue_valid = 1'b0;
    repeat (16) @(posedge clk);
    #1;
    flush = 1'b1;
    chk("wb flush we", 32'(reg_write_en), 32'd1);
    chk("wb flush data", 32'(reg_write_data), 32'h2A);
    chk("wb flush dest", 32'(reg_write_dest), 32'd6);
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("wb flush ready", 32'(issue_ready), 32'd1);

    // async reset mid-CALC
    issue_op = 2'b10;
    issue_rd = 3'd7;
    op_a = 16'd1000;
    op_b = 16'd3;
    issue_valid = 1'b1;
    @(posedge clk);
    #1;
    issue_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("arst busy_pre", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst busy", 32'(busy), 32'd0);
    chk("arst we", 32'(reg_write_en), 32'd0);
    chk("arst ready", 32'(issue_ready), 32'd1);
    chk("arst data", 32'(reg_write_data), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      if (reg_write_en) pulses++;
    end
    chk("arst no_write", 32'(pulses), 32'd0);
    run_op("divu_post", 2'b10, 3'd7, 16'd1000, 16'd3, 16'h014D);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
